// File: rtl/fetch_queue_stage_pkg.sv
// Shared fetch-stage definitions: word/PC constants, queue entry layout and
// the alignment helper used by the fetch stage and its storage.
package fetch_queue_stage_pkg;

    localparam int          INSTR_W    = 32;
    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0800;

    // One buffered fetch: done=1 once the instruction word is known,
    // exc=1 marks an address-error entry that never touched memory.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic               done;
        logic               exc;
    } fq_entry_t;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return (pc[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// In-order circular storage for fetch entries. Besides push/pop it fills the
// oldest entry still waiting for memory, reports how many entries would still
// be waiting after this cycle's fill, and clears on redirect.
module fetch_queue_stage_fifo
    import fetch_queue_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  fq_entry_t          push_entry,
    input  logic               pop,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_data,
    output fq_entry_t          head_entry,
    output logic [PTR_W:0]     count,
    output logic [PTR_W:0]     pending_after
);

    fq_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] slot;
    logic [PTR_W-1:0] fill_idx;
    logic             fill_hit;
    logic [PTR_W:0]   pending_cnt;
    logic             fill_do;
    logic             head_fill;

    // Scan from the head for the oldest pending entry and count all pending ones.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise paths that skip an assignment infer a latch.
        slot        = '0;
        fill_idx    = '0;
        fill_hit    = 1'b0;
        pending_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_ptr + PTR_W'(k);
            if ((PTR_W + 1)'(k) < count && !entries[slot].done) begin
                pending_cnt = pending_cnt + (PTR_W + 1)'(1);
                if (!fill_hit) begin
                    fill_hit = 1'b1;
                    fill_idx = slot;
                end
            end
        end
    end

    assign fill_do       = fill & fill_hit;
    assign head_fill     = fill_do && (fill_idx == head_ptr);
    assign pending_after = pending_cnt - (PTR_W + 1)'(fill_do);

    // Head view with write-through so a response can be decoded the cycle it returns.
    always_comb begin
        head_entry = entries[head_ptr];
        if (head_fill) begin
            head_entry.instr = fill_data;
            head_entry.done  = 1'b1;
        end
    end

    // Pointer, count and entry updates; redirect clears occupancy only.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            // NOTE: entry storage is reset on purpose so the head outputs read as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (fill_do) begin
                entries[fill_idx].instr <= fill_data;
                entries[fill_idx].done  <= 1'b1;
            end
            if (push) begin
                entries[tail_ptr] <= push_entry;
                tail_ptr          <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: issues in-order fetches at the current PC, buffers
// {pc, instr} pairs for decode, holds the PC when no entry is taken and
// discards in-flight work on redirect.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_hold,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_exc_adel
);

    logic [PTR_W:0]   count;
    logic [PTR_W:0]   drop_cnt;
    logic [PTR_W:0]   pending_after;
    logic [PTR_W+1:0] occupancy;
    logic             credit;
    logic             aligned;
    logic             push_exc;
    logic             push;
    logic             pop;
    logic             dropping;
    logic             fill;
    fq_entry_t        head_entry;
    fq_entry_t        push_entry;

    // Credit counts queued entries plus responses still owed from before a redirect;
    // a pop in the same cycle does not free a slot until the next cycle.
    assign occupancy = {1'b0, count} + {1'b0, drop_cnt};
    assign credit    = occupancy < (PTR_W + 2)'(DEPTH);
    assign aligned   = pc_aligned(pc_in);

    assign imem_req  = aligned & credit & ~flush & ~reset;
    assign imem_addr = pc_in;
    assign push_exc  = ~aligned & credit & ~flush & ~reset;
    assign push      = (imem_req & imem_gnt) | push_exc;
    assign pc_hold   = ~push;

    assign push_entry = '{pc: pc_in, instr: '0, done: push_exc, exc: push_exc};

    assign dropping = imem_rvalid & (drop_cnt != '0);
    assign fill     = imem_rvalid & (drop_cnt == '0) & ~reset;

    assign id_valid    = (count != '0) & head_entry.done & ~flush & ~reset;
    assign pop         = id_valid & id_ready;
    assign id_instr    = head_entry.instr;
    assign id_pc       = head_entry.pc;
    assign id_pc4      = head_entry.pc + PC_INC;
    assign id_exc_adel = head_entry.exc;

    // Responses owed to fetches abandoned by a redirect; they are swallowed first.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_cnt - (PTR_W + 1)'(dropping) + pending_after;
        end else if (dropping) begin
            drop_cnt <= drop_cnt - (PTR_W + 1)'(1);
        end
    end

    fetch_queue_stage_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .clear         (flush),
        .push          (push),
        .push_entry    (push_entry),
        .pop           (pop),
        .fill          (fill),
        .fill_data     (imem_rdata),
        .head_entry    (head_entry),
        .count         (count),
        .pending_after (pending_after)
    );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: an in-order memory model with
// configurable latency and a scoreboard of expected decode entries.
module tb_fetch_queue_stage;
    import fetch_queue_stage_pkg::*;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_hold;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_exc_adel;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];
    int    n_cmp   = 0;
    int    n_mis   = 0;
    int    cyc     = 0;
    int    lat     = 1;
    int    pops    = 0;
    bit    pc_auto = 1'b0;

    always #5 clk = ~clk;

    fetch_queue_stage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_hold     (pc_hold),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_exc_adel (id_exc_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h2402_000A ^ ((pc - 32'h0000_1000) << 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive this cycle's memory response, then move to the sampling point.
    task automatic begin_cycle();
        if (!reset && resp_q.size() > 0 && resp_q[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = resp_q[0].data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
    endtask

    // Score the decode handshake, record grants/pushes, then cross the edge.
    task automatic end_cycle();
        exp_t  e;
        resp_t r;
        bit    advance;
        if (reset) begin
            exp_q.delete();
            resp_q.delete();
        end else begin
            if (id_valid && id_ready) begin
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_pc",    id_pc,       e.pc);
                    check("sb_instr", id_instr,    e.instr);
                    check("sb_pc4",   id_pc4,      e.pc + 32'd4);
                    check("sb_exc",   id_exc_adel, e.exc);
                end
                pops++;
            end
            if (imem_rvalid) r = resp_q.pop_front();
            if (flush) begin
                exp_q.delete();
            end else if (imem_req && imem_gnt) begin
                resp_q.push_back('{cyc + lat, mem_word(imem_addr)});
                exp_q.push_back('{pc_in, mem_word(pc_in), 1'b0});
            end else if (!imem_req && !pc_hold) begin
                exp_q.push_back('{pc_in, 32'h0, 1'b1});
            end
        end
        advance = !reset && !flush && !pc_hold;
        @(posedge clk);
        #1;
        cyc++;
        if (pc_auto && advance) pc_in = pc_in + 32'd4;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        pc_in       = 32'h0000_1000;
        flush       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b1;

        // Reset held two cycles
        begin_cycle();
        check("rst_req",  imem_req, 32'd0);
        check("rst_hold", pc_hold,  32'd1);
        end_cycle();
        begin_cycle();
        check("rst_valid", id_valid,    32'd0);
        check("rst_pc",    id_pc,       32'd0);
        check("rst_pc4",   id_pc4,      32'd4);
        check("rst_instr", id_instr,    32'd0);
        check("rst_exc",   id_exc_adel, 32'd0);
        check("rst_req2",  imem_req,    32'd0);
        end_cycle();

        // First fetch out of reset
        reset   = 1'b0;
        pc_auto = 1'b1;
        begin_cycle();
        check("first_req",  imem_req, 32'd1);
        check("first_hold", pc_hold,  32'd0);
        end_cycle();
        begin_cycle();
        check("first_valid", id_valid, 32'd1);
        check("first_pc",    id_pc,    32'h0000_1000);
        check("first_pc4",   id_pc4,   32'h0000_1004);
        check("first_instr", id_instr, 32'h2402_000A);
        end_cycle();

        // Streaming at one instruction per cycle
        pops = 0;
        step(6);
        check("stream_rate", pops, 32'd6);

        // Decode back-pressure fills the queue
        id_ready = 1'b0;
        step(3);
        begin_cycle();
        check("bp_req",   imem_req,  32'd0);
        check("bp_hold",  pc_hold,   32'd1);
        check("bp_count", dut.count, 32'd2);
        check("bp_valid", id_valid,  32'd1);
        end_cycle();
        id_ready = 1'b1;
        begin_cycle();
        check("bp_release_req", imem_req, 32'd0);
        end_cycle();
        begin_cycle();
        check("bp_reissue_req", imem_req, 32'd1);
        end_cycle();
        step(3);

        // Drain, then redirect with two slow fetches outstanding
        imem_gnt = 1'b0;
        step(4);
        check("drained", exp_q.size(), 32'd0);
        lat      = 3;
        imem_gnt = 1'b1;
        step(2);
        flush = 1'b1;
        begin_cycle();
        check("flush_valid", id_valid, 32'd0);
        check("flush_hold",  pc_hold,  32'd1);
        check("flush_req",   imem_req, 32'd0);
        end_cycle();
        flush = 1'b0;
        pc_in = EXC_VECTOR;
        begin_cycle();
        check("flush_drop_cnt", dut.drop_cnt, 32'd2);
        check("flush_count",    dut.count,    32'd0);
        check("flush_no_credit", imem_req,    32'd0);
        end_cycle();
        pops = 0;
        step(12);
        check("post_flush_delivered", 32'(pops != 0), 32'd1);

        // Misaligned PC produces an address-error entry
        lat      = 1;
        imem_gnt = 1'b0;
        step(6);
        pc_auto = 1'b0;
        pc_in   = 32'h0000_1002;
        begin_cycle();
        check("mis_req",  imem_req, 32'd0);
        check("mis_hold", pc_hold,  32'd0);
        end_cycle();
        pc_in    = 32'hFFFF_FFFC;
        imem_gnt = 1'b1;
        begin_cycle();
        check("mis_valid", id_valid,    32'd1);
        check("mis_exc",   id_exc_adel, 32'd1);
        check("mis_instr", id_instr,    32'd0);
        check("mis_pc",    id_pc,       32'h0000_1002);
        end_cycle();

        // PC+4 wraps at the top of the address space
        imem_gnt = 1'b0;
        begin_cycle();
        check("wrap_valid", id_valid, 32'd1);
        check("wrap_pc4",   id_pc4,   32'h0000_0000);
        end_cycle();

        // No grant: PC held and nothing buffered
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            check("nognt_hold", pc_hold,  32'd1);
            check("nognt_req",  imem_req, 32'd1);
            end_cycle();
        end
        check("nognt_count", dut.count, 32'd0);
        check("nognt_valid", id_valid,  32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
